// File: rtl/wb_pkg.sv
// Shared constants for the Wishbone region slave.
// FSM state encoding, bus width, default base address and clog2.
package wb_pkg;

    localparam int DW = 32;
    localparam logic [31:0] BASE_DEFAULT = 32'h3000_0000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_region_decode.sv
// Address decoder: splits the bus address into equal regions above BASE_ADDR.
// Receives only ADR_I[31:REGION_AW]; the in-region offset is not needed here.
module wb_region_decode
    import wb_pkg::*;
#(
    parameter int          NUM_REGIONS = 2,
    parameter int          REGION_AW   = 7,
    parameter logic [31:0] BASE_ADDR   = BASE_DEFAULT,
    localparam int         IDXW        = clog2(NUM_REGIONS),
    localparam int         IW          = (IDXW == 0) ? 1 : IDXW
) (
    input  logic [31-REGION_AW:0] i_adr_hi,
    output logic                  o_hit,
    output logic [IW-1:0]         o_idx
);

    localparam logic [31-REGION_AW:0] BASE_HI = BASE_ADDR[31:REGION_AW];

    logic w_tag_ok;
    logic w_in_range;

    assign w_tag_ok = (i_adr_hi >> IDXW) == (BASE_HI >> IDXW);

    generate
        if (IDXW == 0) begin : g_one
            assign o_idx      = '0;
            assign w_in_range = 1'b1;
        end else begin : g_many
            localparam logic [IW:0] NR = (IW + 1)'(NUM_REGIONS);
            assign o_idx      = i_adr_hi[IW-1:0];
            assign w_in_range = {1'b0, o_idx} < NR;
        end
    endgenerate

    assign o_hit = w_tag_ok && w_in_range;

endmodule

// File: rtl/wb_region_slave.sv
// Wishbone classic slave fanning transfers out to NUM_REGIONS devices
// with a one-cycle request pulse and a device-paced acknowledge.
module wb_region_slave
    import wb_pkg::*;
#(
    parameter int          NUM_REGIONS = 2,
    parameter int          REGION_AW   = 7,
    parameter logic [31:0] BASE_ADDR   = BASE_DEFAULT,
    parameter int          DW          = wb_pkg::DW,
    parameter int          TIMEOUT     = 15,
    localparam int         IDXW        = clog2(NUM_REGIONS),
    localparam int         IW          = (IDXW == 0) ? 1 : IDXW
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic                      CYC_I,
    input  logic                      STB_I,
    input  logic                      WE_I,
    input  logic [DW/8-1:0]           SEL_I,
    input  logic [31:0]               ADR_I,
    input  logic [DW-1:0]             DAT_I,
    output logic                      ACK_O,
    output logic                      ERR_O,
    output logic [DW-1:0]             DAT_O,
    output logic [NUM_REGIONS-1:0]    DEV_REQ,
    output logic                      DEV_WE,
    output logic [REGION_AW-3:0]      DEV_ADDR,
    output logic [DW-1:0]             DEV_WDATA,
    output logic [DW/8-1:0]           DEV_BE,
    input  logic [NUM_REGIONS*DW-1:0] DEV_RDATA,
    input  logic [NUM_REGIONS-1:0]    DEV_ACK
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    localparam logic [NUM_REGIONS-1:0] ONE = NUM_REGIONS'(1);

    logic [1:0]             r_state;
    logic [7:0]             r_cnt;
    logic [IW-1:0]          r_idx;
    logic                   r_ack;
    logic                   r_err;
    logic [DW-1:0]          r_dat;
    logic [NUM_REGIONS-1:0] r_req;
    logic                   r_we;
    logic [REGION_AW-3:0]   r_addr;
    logic [DW-1:0]          r_wdata;
    logic [DW/8-1:0]        r_be;

    logic                   w_hit;
    logic [IW-1:0]          w_idx;
    logic                   w_ack_sel;
    logic [DW-1:0]          w_rdata_sel;
    logic [7:0]             w_cnt_nx;
    logic                   w_unused;

    wb_region_decode #(
        .NUM_REGIONS(NUM_REGIONS),
        .REGION_AW  (REGION_AW),
        .BASE_ADDR  (BASE_ADDR)
    ) u_dec (
        .i_adr_hi(ADR_I[31:REGION_AW]),
        .o_hit   (w_hit),
        .o_idx   (w_idx)
    );

    // Byte offset within a word carries no meaning for word devices.
    assign w_unused    = ^ADR_I[1:0];
    assign w_ack_sel   = DEV_ACK[r_idx];
    assign w_rdata_sel = DEV_RDATA[int'(r_idx)*DW +: DW];
    assign w_cnt_nx    = r_cnt + 8'd1;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_req   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_req <= '0;
            case (r_state)
                S_IDLE: begin
                    if (CYC_I && STB_I) begin
                        if (w_hit) begin
                            r_idx   <= w_idx;
                            r_we    <= WE_I;
                            r_addr  <= ADR_I[REGION_AW-1:2];
                            r_wdata <= DAT_I;
                            r_be    <= WE_I ? SEL_I : '1;
                            r_req   <= ONE << w_idx;
                            r_cnt   <= '0;
                            r_state <= S_WAIT;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_WAIT: begin
                    if (!CYC_I) begin
                        r_state <= S_IDLE;
                    end else if (w_ack_sel) begin
                        if (!r_we) r_dat <= w_rdata_sel;
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_nx;
                        if (w_cnt_nx == TO_LIM) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ACK_O     = r_ack;
    assign ERR_O     = r_err;
    assign DAT_O     = r_dat;
    assign DEV_REQ   = r_req;
    assign DEV_WE    = r_we;
    assign DEV_ADDR  = r_addr;
    assign DEV_WDATA = r_wdata;
    assign DEV_BE    = r_be;

endmodule

// File: tb/tb_wb_region_slave.sv
// Self-checking bench for wb_region_slave (default parameters).
// The bench plays both the Wishbone master and the two devices.
module tb_wb_region_slave;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [3:0]  SEL_I;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic        ACK_O;
    logic        ERR_O;
    logic [31:0] DAT_O;
    logic [1:0]  DEV_REQ;
    logic        DEV_WE;
    logic [4:0]  DEV_ADDR;
    logic [31:0] DEV_WDATA;
    logic [3:0]  DEV_BE;
    logic [63:0] DEV_RDATA;
    logic [1:0]  DEV_ACK;

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_dato = 32'h0;

    wb_region_slave dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .CYC_I    (CYC_I),
        .STB_I    (STB_I),
        .WE_I     (WE_I),
        .SEL_I    (SEL_I),
        .ADR_I    (ADR_I),
        .DAT_I    (DAT_I),
        .ACK_O    (ACK_O),
        .ERR_O    (ERR_O),
        .DAT_O    (DAT_O),
        .DEV_REQ  (DEV_REQ),
        .DEV_WE   (DEV_WE),
        .DEV_ADDR (DEV_ADDR),
        .DEV_WDATA(DEV_WDATA),
        .DEV_BE   (DEV_BE),
        .DEV_RDATA(DEV_RDATA),
        .DEV_ACK  (DEV_ACK)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ack_dly: cycles after the REQ sample before the device acks; 0 = never.
    task automatic run_xfer(
        input string       nm,
        input bit          we,
        input logic [31:0] adr,
        input logic [31:0] dat,
        input logic [3:0]  sel,
        input int          ack_dly,
        input logic [31:0] rdev,
        input bit          exp_hit,
        input int          exp_idx,
        input logic [4:0]  exp_addr,
        input logic [3:0]  exp_be,
        input int          exp_lat,
        input bit          noise
    );
        exp_t        e;
        int          req_cyc;
        int          n_req;
        int          resp_cyc;
        logic [1:0]  req_val;
        logic        f_we;
        logic [4:0]  f_addr;
        logic [3:0]  f_be;
        logic [31:0] f_wd;
        logic        r_ack;
        logic        r_err;
        logic [31:0] r_dat;
        e.is_err = !exp_hit || (ack_dly == 0);
        e.dat    = (!e.is_err && !we) ? rdev : exp_dato;
        e.lat    = exp_lat;
        sbq.push_back(e);
        req_cyc  = -1;
        n_req    = 0;
        resp_cyc = -1;
        req_val  = 2'b00;
        f_we = 1'b0; f_addr = '0; f_be = '0; f_wd = '0;
        r_ack = 1'b0; r_err = 1'b0; r_dat = '0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we;
        ADR_I = adr; DAT_I = dat; SEL_I = sel;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK_I); #1;
            if (DEV_REQ !== 2'b00) begin
                n_req++;
                if (req_cyc < 0) begin
                    req_cyc = c;
                    req_val = DEV_REQ;
                    f_we = DEV_WE; f_addr = DEV_ADDR;
                    f_be = DEV_BE; f_wd = DEV_WDATA;
                end
            end
            if (ACK_O === 1'b1 || ERR_O === 1'b1) begin
                resp_cyc = c;
                r_ack = ACK_O; r_err = ERR_O; r_dat = DAT_O;
                break;
            end
            DEV_ACK = 2'b00;
            if (req_cyc > 0 && ack_dly > 0 && c == req_cyc + ack_dly) begin
                DEV_ACK[exp_idx] = 1'b1;
                DEV_RDATA[exp_idx*32 +: 32] = rdev;
            end else if (noise && c == 2) begin
                DEV_ACK[1-exp_idx] = 1'b1;
            end
        end
        DEV_ACK = 2'b00;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        n_vec++;
        if (resp_cyc < 0) begin
            n_err++;
            $display("FAIL %s_timeout: no ACK_O/ERR_O within 40 cycles", nm);
            void'(sbq.pop_front());
            return;
        end
        e = sbq.pop_front();
        n_vec++;
        if ({r_ack, r_err} !== {!e.is_err, e.is_err}) begin
            n_err++;
            $display("FAIL %s_resp: ack/err got %b%b want %b%b",
                     nm, r_ack, r_err, !e.is_err, e.is_err);
        end
        n_vec++;
        if (resp_cyc != e.lat) begin
            n_err++;
            $display("FAIL %s_lat: got %0d want %0d", nm, resp_cyc, e.lat);
        end
        n_vec++;
        if (r_dat !== e.dat) begin
            n_err++;
            $display("FAIL %s_dato: got %h want %h", nm, r_dat, e.dat);
        end
        exp_dato = e.dat;
        n_vec++;
        if (n_req != (exp_hit ? 1 : 0)) begin
            n_err++;
            $display("FAIL %s_nreq: got %0d want %0d", nm, n_req, exp_hit ? 1 : 0);
        end
        if (exp_hit) begin
            n_vec++;
            if (req_val !== 2'(1 << exp_idx) || req_cyc != 1) begin
                n_err++;
                $display("FAIL %s_req: got %b@%0d want %b@1",
                         nm, req_val, req_cyc, 2'(1 << exp_idx));
            end
            n_vec++;
            if ({f_we, f_addr, f_be, f_wd} !== {we, exp_addr, exp_be, dat}) begin
                n_err++;
                $display("FAIL %s_fields: we/addr/be/wd got %b %h %b %h want %b %h %b %h",
                         nm, f_we, f_addr, f_be, f_wd, we, exp_addr, exp_be, dat);
            end
            n_vec++;
            if (DEV_ADDR !== exp_addr) begin
                n_err++;
                $display("FAIL %s_hold: DEV_ADDR got %h want %h", nm, DEV_ADDR, exp_addr);
            end
        end
        @(posedge CLK_I); #1;
        n_vec++;
        if (ACK_O !== 1'b0 || ERR_O !== 1'b0 || DEV_REQ !== 2'b00) begin
            n_err++;
            $display("FAIL %s_pulse: ack/err/req got %b%b%b want 0000",
                     nm, ACK_O, ERR_O, DEV_REQ);
        end
    endtask

    task automatic test_reset();
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        SEL_I = '0; ADR_I = '0; DAT_I = '0;
        DEV_RDATA = '0; DEV_ACK = '0;
        repeat (2) @(posedge CLK_I);
        #1;
        n_vec++;
        if ({ACK_O, ERR_O, DAT_O, DEV_REQ, DEV_WE, DEV_ADDR, DEV_WDATA, DEV_BE} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%b err=%b dat=%h req=%b", ACK_O, ERR_O, DAT_O, DEV_REQ);
        end
        RST_I = 1'b0;
        @(posedge CLK_I); #1;
    endtask

    task automatic test_write();
        run_xfer("wr0", 1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 4'b0011,
                 1, 32'h0, 1'b1, 0, 5'd2, 4'b0011, 3, 1'b0);
    endtask

    task automatic test_read();
        run_xfer("rd1", 1'b0, 32'h3000_0084, 32'h0BAD_F00D, 4'b0001,
                 4, 32'h1234_5678, 1'b1, 1, 5'd1, 4'hF, 6, 1'b1);
        run_xfer("rd0", 1'b0, 32'h3000_007C, 32'h0, 4'b0000,
                 2, 32'hCAFE_0001, 1'b1, 0, 5'd31, 4'hF, 4, 1'b0);
    endtask

    task automatic test_unmapped();
        run_xfer("miss_idx", 1'b0, 32'h3000_0100, 32'h0, 4'hF,
                 1, 32'h5555_5555, 1'b0, 0, 5'd0, 4'h0, 1, 1'b0);
        run_xfer("miss_base", 1'b0, 32'h4000_0000, 32'h0, 4'hF,
                 1, 32'h5555_5555, 1'b0, 0, 5'd0, 4'h0, 1, 1'b0);
    endtask

    task automatic test_timeout();
        run_xfer("tmo", 1'b0, 32'h3000_0010, 32'h0, 4'hF,
                 0, 32'h0, 1'b1, 0, 5'd4, 4'hF, 16, 1'b0);
        run_xfer("after_tmo", 1'b1, 32'h3000_0014, 32'hA5A5_0F0F, 4'b1100,
                 1, 32'h0, 1'b1, 0, 5'd5, 4'b1100, 3, 1'b0);
    endtask

    task automatic test_abort();
        int bad;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0;
        ADR_I = 32'h3000_0020; SEL_I = 4'hF; DAT_I = '0;
        @(posedge CLK_I); #1;
        n_vec++;
        if (DEV_REQ !== 2'b01) begin
            n_err++;
            $display("FAIL abort_req: got %b want 01", DEV_REQ);
        end
        CYC_I = 1'b0; STB_I = 1'b0;
        @(posedge CLK_I); #1;
        DEV_ACK = 2'b01;
        DEV_RDATA[31:0] = 32'hFFFF_0000;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK_I); #1;
            DEV_ACK = 2'b00;
            if (ACK_O !== 1'b0 || ERR_O !== 1'b0 || DEV_REQ !== 2'b00) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d noisy cycles want 0", bad);
        end
        n_vec++;
        if (DAT_O !== exp_dato) begin
            n_err++;
            $display("FAIL abort_dato: got %h want %h", DAT_O, exp_dato);
        end
        run_xfer("after_abort", 1'b0, 32'h3000_0024, 32'h0, 4'h0,
                 1, 32'h7777_8888, 1'b1, 0, 5'd9, 4'hF, 3, 1'b0);
    endtask

    task automatic test_reset_mid();
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
        ADR_I = 32'h3000_0088; SEL_I = 4'b1010; DAT_I = 32'h1357_9BDF;
        @(posedge CLK_I); #1;
        n_vec++;
        if (DEV_REQ !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_req: got %b want 10", DEV_REQ);
        end
        @(posedge CLK_I); #2;
        RST_I = 1'b1;
        #1;
        n_vec++;
        if ({ACK_O, ERR_O, DAT_O, DEV_REQ, DEV_WE, DEV_ADDR, DEV_WDATA, DEV_BE} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got dat=%h we=%b addr=%h wd=%h be=%b",
                     DAT_O, DEV_WE, DEV_ADDR, DEV_WDATA, DEV_BE);
        end
        exp_dato = 32'h0;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        DEV_ACK = 2'b10;
        @(posedge CLK_I); #1;
        DEV_ACK = 2'b00;
        RST_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1;
        n_vec++;
        if (ACK_O !== 1'b0 || ERR_O !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_quiet: ack/err got %b%b want 00", ACK_O, ERR_O);
        end
    endtask

    task automatic test_back_to_back();
        run_xfer("b2b0", 1'b1, 32'h3000_0000, 32'h0000_1111, 4'b0001,
                 1, 32'h0, 1'b1, 0, 5'd0, 4'b0001, 3, 1'b0);
        run_xfer("b2b1", 1'b1, 32'h3000_00FC, 32'h2222_0000, 4'b1000,
                 1, 32'h0, 1'b1, 1, 5'd31, 4'b1000, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
